rotate_right_seq: RTL



---
 rtl/rotate_right_seq_pkg.sv | 13 +
 rtl/rotate_right_seq.sv | 77 +++++++
 2 files changed

// File: rtl/rotate_right_seq_pkg.sv
// rtl/rotate_right_seq_pkg.sv - shared state encoding and default widths for the rotator
package rotate_right_seq_pkg;

    localparam int DW_DEF = 8;
    localparam int KW_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_right_seq.sv
// rtl/rotate_right_seq.sv - sequential rotate-right, one bit per clock, valid/ready handshake
module rotate_right_seq
    import rotate_right_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [KW-1:0] k_i,
    input  logic [DW-1:0] a_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] y_o,
    output logic          busy_o
);

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] sreg_q;
    logic [KW-1:0] cnt_q;
    logic          accept;

    assign accept = valid_i && (state_q == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sreg_q <= a_i;
                cnt_q  <= k_i;
            end else if (state_q == ST_SHIFT) begin
                sreg_q <= {sreg_q[0], sreg_q[DW-1:1]};
                // Counter saturates at zero rather than wrapping.
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = (k_i != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q <= KW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == ST_IDLE);
        valid_o = (state_q == ST_DONE);
        busy_o  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        y_o     = sreg_q;
    end

endmodule
